// File: rtl/sram_row_streamer_if.sv
// Bus bundle between the row streamer, the SRAM macro read port and the
// compute-array stream sink.
interface sram_row_streamer_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6
);
  logic                  sram_csb;
  logic                  sram_wsb;
  logic [ADDR_WIDTH-1:0] sram_raddr;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output sram_csb, sram_wsb, sram_raddr,
    input  sram_rdata,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  sram_csb, sram_wsb, sram_raddr,
    output sram_rdata,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/sram_row_streamer.sv
// Streams len consecutive SRAM rows starting at base_addr onto a valid/ready
// stream. Reads are throttled so that rows in flight plus rows buffered never
// exceed the 2-entry skid FIFO, which lets the sink stall at any time.
module sram_row_streamer #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  sram_row_streamer_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH:0]   delivered_q;
  logic                  inflight_q;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  // Stream side is presented straight from the FIFO head.
  assign pop          = bus.m_valid & bus.m_ready;
  assign push         = inflight_q;
  assign bus.m_valid  = (fifo_cnt != 2'd0);
  assign bus.m_data   = fifo_mem[rd_ptr];
  assign bus.m_last   = bus.m_valid && (delivered_q == len_q - 1'b1);

  assign bus.sram_csb   = ~issue;
  assign bus.sram_wsb   = 1'b1;
  assign bus.sram_raddr = (state_q == RUN) ? base_q + issued_q[ADDR_WIDTH-1:0] : '0;

  assign busy = (state_q != IDLE);
  assign done = done_q;

  // Next-state, read-issue and completion decode.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Buffered + in-flight rows, after this cycle's pop, must stay below 2.
        issue = (issued_q < len_q) &&
                (({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
        if ((issued_q + {{ADDR_WIDTH{1'b0}}, issue}) == len_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && bus.m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Job parameters plus issue/delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
    end else if (accept) begin
      base_q      <= base_addr;
      len_q       <= len;
      issued_q    <= '0;
      delivered_q <= '0;
    end else begin
      if (issue) issued_q <= issued_q + 1'b1;
      if (pop)   delivered_q <= delivered_q + 1'b1;
    end
  end

  // One-cycle SRAM read latency tracker: data of a read lands the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
    end
  end

  // Two-entry skid FIFO; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.sram_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
